apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_bridge_if.sv | 35 +++
 rtl/apb_addr_decoder.sv | 23 ++
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge slice.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [15:0] APB_BASE_HI   = 16'h1000;
  localparam int          APB_SLV_SHIFT = 12;
  localparam int          DATA_W        = 32;

endpackage

// File: rtl/apb_master_bridge_if.sv
// CPU request/response port plus APB bus, grouped for the bridge and its environment.
interface apb_master_bridge_if #(
  parameter int NUM_SLV = 4
);
  logic                  req_valid;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [31:0]           PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE;
  logic [NUM_SLV-1:0]    PSEL;
  logic                  PENABLE;
  logic [32*NUM_SLV-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral decode: window hit, slave index and one-hot select.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4
) (
  input  logic [DATA_W-1:APB_SLV_SHIFT] addr_hi,
  output logic                          hit,
  output logic [3:0]                    idx,
  output logic [NUM_SLV-1:0]            onehot
);

  assign idx = addr_hi[APB_SLV_SHIFT +: 4];

  always_comb begin
    hit    = (addr_hi[DATA_W-1:16] == APB_BASE_HI) && (int'(idx) < NUM_SLV);
    onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit && (idx == 4'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: CPU request/response port to NUM_SLV APB slaves.
// Optional ACCESS-phase abort is built when APB_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus
);

  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("apb_master_bridge: NUM_SLV must be 1..16 and TIMEOUT >= 1");
  end

  apb_state_e          state_q;
  logic [DATA_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic                penable_q;
  logic [3:0]          idx_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic                dec_hit;
  logic [3:0]          dec_idx;
  logic [NUM_SLV-1:0]  dec_onehot;
  logic                accept;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

  apb_addr_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
    .addr_hi (bus.req_addr[DATA_W-1:APB_SLV_SHIFT]),
    .hit     (dec_hit),
    .idx     (dec_idx),
    .onehot  (dec_onehot)
  );

  assign accept = bus.req_valid && req_ready_q;

  // Only the addressed slave's PREADY and read lane matter.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready = bus.PREADY[i];
        sel_rdata = bus.PRDATA[DATA_W*i +: DATA_W];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      idx_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            if (dec_hit) begin
              paddr_q     <= bus.req_addr;
              pwdata_q    <= bus.req_wdata;
              pwrite_q    <= bus.req_write;
              psel_q      <= dec_onehot;
              idx_q       <= dec_idx;
              req_ready_q <= 1'b0;
              state_q     <= SETUP;
            end else begin
              // Decode miss answers directly without touching the bus.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (sel_ready) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : sel_rdata;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          // Ready in the same cycle as the last allowed count still wins above.
          else if (tmo_cnt_q == TMO_LAST) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          psel_q      <= '0;
          penable_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a behavioural slave/response model.
module tb_apb_master_bridge;

  localparam int NUM_SLV = 4;
`ifdef APB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic PCLK;
  logic PRESET;

  apb_master_bridge_if #(.NUM_SLV(NUM_SLV)) bus ();

  apb_master_bridge #(.NUM_SLV(NUM_SLV), .TIMEOUT(TMO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] lane_val [NUM_SLV];
  int          wait_cfg [NUM_SLV];
  int          acc_cnt  [NUM_SLV];
  bit          noise_en;

  typedef struct {
    logic [31:0]        rd;
    logic               er;
    int                 lat;
    int                 acc;
    logic [NUM_SLV-1:0] psel1;
    logic               pen1;
    logic [31:0]        paddr1;
    logic [31:0]        pwdata1;
    logic               pwrite1;
  } obs_t;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  always_comb begin
    bus.PRDATA = '0;
    for (int i = 0; i < NUM_SLV; i++) bus.PRDATA[32*i +: 32] = lane_val[i];
  end

  // Slave model: ready after wait_cfg[i] extra ACCESS cycles; unselected slaves may toggle noise.
  always @(negedge PCLK) begin
    for (int i = 0; i < NUM_SLV; i++) begin
      if (bus.PSEL[i] && bus.PENABLE) begin
        acc_cnt[i]++;
        bus.PREADY[i] = (acc_cnt[i] > wait_cfg[i]);
      end else begin
        acc_cnt[i] = 0;
        bus.PREADY[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Protocol monitor
  logic [NUM_SLV-1:0] prev_psel = '0;
  logic [31:0]        prev_paddr = '0;
  always @(negedge PCLK) begin
    if (!PRESET) begin
      vectors++;
      if ($countones(bus.PSEL) > 1) begin
        miscompares++;
        $display("FAIL psel_onehot: got PSEL=%b required at most one bit", bus.PSEL);
      end
      if (bus.PSEL != 0 && prev_psel == 0) begin
        vectors++;
        if (bus.PENABLE !== 1'b0) begin
          miscompares++;
          $display("FAIL penable_first: got PENABLE=%b required 0 in first PSEL cycle", bus.PENABLE);
        end
      end
      if (bus.PSEL != 0 && prev_psel == bus.PSEL) begin
        vectors++;
        if (bus.PADDR !== prev_paddr) begin
          miscompares++;
          $display("FAIL paddr_stable: got %h required %h", bus.PADDR, prev_paddr);
        end
      end
      if (bus.PENABLE === 1'b1) begin
        vectors++;
        if (bus.PSEL == 0) begin
          miscompares++;
          $display("FAIL penable_no_psel: got PSEL=%b required nonzero with PENABLE", bus.PSEL);
        end
      end
    end
    prev_psel  = bus.PSEL;
    prev_paddr = bus.PADDR;
  end

  function automatic void model(input logic [31:0] a, output bit hit, output int s);
    hit = (a[31:16] == 16'h1000) && (int'(a[15:12]) < NUM_SLV);
    s   = int'(a[15:12]);
  endfunction

  // Issues one request from a negedge and observes until the response; returns at that negedge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output obs_t o);
    int n;
    o = '{rd: '0, er: 1'b0, lat: -1, acc: 0, psel1: '0, pen1: 1'b0,
          paddr1: '0, pwdata1: '0, pwrite1: 1'b0};
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (k == 1) begin
        o.psel1   = bus.PSEL;
        o.pen1    = bus.PENABLE;
        o.paddr1  = bus.PADDR;
        o.pwdata1 = bus.PWDATA;
        o.pwrite1 = bus.PWRITE;
      end
      if (bus.PENABLE === 1'b1) o.acc++;
      if (bus.rsp_valid === 1'b1) begin
        o.rd  = bus.rsp_rdata;
        o.er  = bus.rsp_err;
        o.lat = k;
        break;
      end
      @(negedge PCLK);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    @(negedge PCLK);
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.PADDR, bus.PWDATA,
         bus.PWRITE, bus.PSEL, bus.PENABLE} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h err=%b paddr=%h pwdata=%h pw=%b psel=%b pen=%b required all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.PADDR, bus.PWDATA,
               bus.PWRITE, bus.PSEL, bus.PENABLE);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_ready: got req_ready=%b required 1", bus.req_ready);
    end
  endtask

  task automatic test_write_slave0();
    obs_t o;
    wait_cfg[0] = 1;
    xfer(1'b1, 32'h1000_0000, 32'h0000_0001, o);
    vectors++;
    if ({o.psel1, o.pen1} !== {4'b0001, 1'b0}) begin
      miscompares++;
      $display("FAIL wr0_setup: got psel=%b pen=%b required 0001/0", o.psel1, o.pen1);
    end
    vectors++;
    if (o.pwdata1 !== 32'h1 || o.pwrite1 !== 1'b1) begin
      miscompares++;
      $display("FAIL wr0_pwdata: got %h/%b required 00000001/1", o.pwdata1, o.pwrite1);
    end
    vectors++;
    if (o.acc !== 2 || o.lat !== 4) begin
      miscompares++;
      $display("FAIL wr0_timing: got access=%0d lat=%0d required 2/4", o.acc, o.lat);
    end
    vectors++;
    if (o.rd !== 32'h0 || o.er !== 1'b0) begin
      miscompares++;
      $display("FAIL wr0_rsp: got rdata=%h err=%b required 0/0", o.rd, o.er);
    end
  endtask

  task automatic test_read_wait();
    obs_t o;
    wait_cfg[1] = 3;
    lane_val[1] = 32'h0000_00AB;
    xfer(1'b0, 32'h1000_1004, 32'h0, o);
    vectors++;
    if (o.psel1 !== 4'b0010 || o.paddr1 !== 32'h1000_1004) begin
      miscompares++;
      $display("FAIL rd1_setup: got psel=%b paddr=%h required 0010/10001004", o.psel1, o.paddr1);
    end
    vectors++;
    if (o.acc !== 4 || o.lat !== 6) begin
      miscompares++;
      $display("FAIL rd1_timing: got access=%0d lat=%0d required 4/6", o.acc, o.lat);
    end
    vectors++;
    if (o.rd !== 32'h0000_00AB || o.er !== 1'b0) begin
      miscompares++;
      $display("FAIL rd1_rsp: got rdata=%h err=%b required 000000ab/0", o.rd, o.er);
    end
  endtask

  task automatic test_decode_miss();
    obs_t o;
    xfer(1'b0, 32'h2000_0000, 32'h0, o);
    vectors++;
    if (o.lat !== 1 || o.psel1 !== '0 || o.acc !== 0) begin
      miscompares++;
      $display("FAIL miss_timing: got lat=%0d psel=%b access=%0d required 1/0000/0", o.lat, o.psel1, o.acc);
    end
    vectors++;
    if (o.rd !== 32'h0 || o.er !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_rsp: got rdata=%h err=%b required 0/1", o.rd, o.er);
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_SLV-1:0] exp_psel [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000,
                                        4'b1000, 4'b1000, 4'b1000, 4'b0000};
    int acc_k;
    wait_cfg[2] = 1;
    wait_cfg[3] = 1;
    acc_k = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h1000_2000;
    bus.req_wdata = 32'h2222_2222;
    @(posedge PCLK);
    for (int k = 1; k <= 8; k++) begin
      @(negedge PCLK);
      if (k == 1) begin
        bus.req_addr  = 32'h1000_3000;
        bus.req_wdata = 32'h3333_3333;
      end
      if (acc_k != 0) bus.req_valid = 1'b0;
      vectors++;
      if (bus.PSEL !== exp_psel[k-1]) begin
        miscompares++;
        $display("FAIL b2b_psel[%0d]: got %b required %b", k, bus.PSEL, exp_psel[k-1]);
      end
      vectors++;
      if (bus.rsp_valid !== ((k == 4) || (k == 8))) begin
        miscompares++;
        $display("FAIL b2b_rsp_valid[%0d]: got %b required %b", k, bus.rsp_valid, (k == 4) || (k == 8));
      end
      if (acc_k == 0 && bus.req_valid && bus.req_ready === 1'b1) acc_k = k;
    end
    bus.req_valid = 1'b0;
    vectors++;
    if (acc_k !== 4) begin
      miscompares++;
      $display("FAIL b2b_accept_cycle: got %0d required 4", acc_k);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int   seen;
    wait_cfg[1] = 1000;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h1000_1000;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    @(negedge PCLK);
    #2;
    PRESET = 1'b1;
    #1;
    vectors++;
    if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_drop: got psel=%b pen=%b required 0/0", bus.PSEL, bus.PENABLE);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_no_rsp: got %0d responses required 0", seen);
    end
    wait_cfg[1] = 1;
    lane_val[1] = 32'h5A5A_0001;
    xfer(1'b0, 32'h1000_1008, 32'h0, o);
    vectors++;
    if (o.rd !== 32'h5A5A_0001 || o.er !== 1'b0 || o.lat !== 4) begin
      miscompares++;
      $display("FAIL post_reset_xfer: got rdata=%h err=%b lat=%0d required 5a5a0001/0/4", o.rd, o.er, o.lat);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        w;
    logic [31:0] a, d, exp_rd;
    bit          hit;
    int          s, kind;
    noise_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        wait_cfg[i] = $urandom_range(0, 4);
        lane_val[i] = $urandom;
      end
      w    = 1'($urandom_range(0, 1));
      d    = $urandom;
      kind = $urandom_range(0, 3);
      if (kind < 2)
        a = {16'h1000, 4'($urandom_range(0, NUM_SLV - 1)), 12'($urandom)};
      else if (kind == 2 && NUM_SLV < 16)
        a = {16'h1000, 4'($urandom_range(NUM_SLV, 15)), 12'($urandom)};
      else
        a = $urandom;
      model(a, hit, s);
      exp_rd = (hit && !w) ? lane_val[s] : 32'h0;
      xfer(w, a, d, o);
      vectors++;
      if (o.rd !== exp_rd || o.er !== !hit) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d] addr=%h w=%b: got rdata=%h err=%b required %h/%b",
                 t, a, w, o.rd, o.er, exp_rd, !hit);
      end
      vectors++;
      if (o.lat !== (hit ? wait_cfg[s] + 3 : 1)) begin
        miscompares++;
        $display("FAIL rand_lat[%0d] addr=%h: got %0d required %0d", t, a, o.lat, hit ? wait_cfg[s] + 3 : 1);
      end
      if (hit) begin
        vectors++;
        if (o.psel1 !== NUM_SLV'(1 << s) || o.paddr1 !== a || o.pwdata1 !== d || o.pwrite1 !== w) begin
          miscompares++;
          $display("FAIL rand_setup[%0d]: got psel=%b paddr=%h pwdata=%h pw=%b required %b/%h/%h/%b",
                   t, o.psel1, o.paddr1, o.pwdata1, o.pwrite1, NUM_SLV'(1 << s), a, d, w);
        end
      end
    end
    noise_en = 1'b0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    wait_cfg[2] = 1000;
    xfer(1'b0, 32'h1000_2000, 32'h0, o);
    vectors++;
    if (o.acc !== TMO || o.lat !== TMO + 2 || o.er !== 1'b1 || o.rd !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout_abort: got access=%0d lat=%0d err=%b rdata=%h required %0d/%0d/1/0",
               o.acc, o.lat, o.er, o.rd, TMO, TMO + 2);
    end
    wait_cfg[2] = TMO - 1;
    lane_val[2] = 32'hC0DE_0002;
    xfer(1'b0, 32'h1000_2000, 32'h0, o);
    vectors++;
    if (o.lat !== TMO + 2 || o.er !== 1'b0 || o.rd !== 32'hC0DE_0002) begin
      miscompares++;
      $display("FAIL timeout_ready_wins: got lat=%0d err=%b rdata=%h required %0d/0/c0de0002",
               o.lat, o.er, o.rd, TMO + 2);
    end
  endtask
`endif

  initial begin
    PRESET        = 1'b1;
    noise_en      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PREADY    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      lane_val[i] = 32'h0;
      wait_cfg[i] = 1;
      acc_cnt[i]  = 0;
    end
    test_reset();
    test_write_slave0();
    test_read_wait();
    test_decode_miss();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
